// File: rtl/redun_carry_resolver.sv
// redun_carry_resolver: converts a redundant-form product (DSP_BIT_LEN-bit limbs,
// each of weight 2^WORD_LEN) into canonical WORD_LEN-bit limbs. Carries ripple
// serially, LIMBS_PER_CYC limbs per clock, and results are written in place
// into the working register.
// Optional feature: define REDUN_CARRY_BYPASS_EN to let inputs that are already
// canonical skip the propagation phase and go straight to DONE.
module redun_carry_resolver #(
    parameter int NUM_ELEMENTS  = 66,
    parameter int DSP_BIT_LEN   = 17,
    parameter int WORD_LEN      = 16,
    parameter int LIMBS_PER_CYC = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_val,
    output logic                   o_rdy,
    input  logic [DSP_BIT_LEN-1:0] i_dat [NUM_ELEMENTS],
    output logic                   o_val,
    input  logic                   i_rdy,
    output logic [WORD_LEN-1:0]    o_dat [NUM_ELEMENTS],
    output logic [1:0]             o_carry
);

    // Number of propagation groups; the last one may be partial.
    localparam int NG = (NUM_ELEMENTS + LIMBS_PER_CYC - 1) / LIMBS_PER_CYC;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    // Index width large enough to address every slot of the last (possibly partial) group.
    localparam int IW = ((NG * LIMBS_PER_CYC) > 1) ? $clog2(NG * LIMBS_PER_CYC) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(NG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grp_q, grp_d;
    logic [1:0]             carry_q, carry_d;
    logic [1:0]             o_carry_q, o_carry_d;
    logic                   o_val_q, o_val_d;
    logic                   o_rdy_q, o_rdy_d;
    logic [DSP_BIT_LEN-1:0] work_q [NUM_ELEMENTS];
    logic [DSP_BIT_LEN-1:0] work_d [NUM_ELEMENTS];

    // Group ripple temporaries. The carry is 2 bits wide: a full limb plus an
    // incoming carry of 2 can produce a carry of 2 out.
    logic [DSP_BIT_LEN-1:0] prop_work [NUM_ELEMENTS];
    logic [1:0]             prop_carry;
    logic [DSP_BIT_LEN:0]   limb_sum;
    logic [IW-1:0]          limb_idx;

    // Resolve the current group LSB first, chaining the carry combinationally.
    always_comb begin
        prop_work  = work_q;
        prop_carry = carry_q;
        limb_sum   = '0;
        limb_idx   = '0;
        for (int j = 0; j < LIMBS_PER_CYC; j++) begin
            if ((int'(grp_q) * LIMBS_PER_CYC + j) < NUM_ELEMENTS) begin
                limb_idx            = IW'(int'(grp_q) * LIMBS_PER_CYC + j);
                limb_sum            = {1'b0, work_q[limb_idx]} + (DSP_BIT_LEN + 1)'(prop_carry);
                prop_work[limb_idx] = DSP_BIT_LEN'(limb_sum[WORD_LEN-1:0]);
                prop_carry          = 2'(limb_sum >> WORD_LEN);
            end
        end
    end

`ifdef REDUN_CARRY_BYPASS_EN
    logic in_canonical;

    // Input is already canonical when no limb has bits above the nominal word.
    always_comb begin
        in_canonical = 1'b1;
        for (int k = 0; k < NUM_ELEMENTS; k++) begin
            if (i_dat[k][DSP_BIT_LEN-1:WORD_LEN] != '0) begin
                in_canonical = 1'b0;
            end
        end
    end
`endif

    // Next-state and registered-output logic of the IDLE/PROP/DONE controller.
    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        carry_d   = carry_q;
        o_carry_d = o_carry_q;
        work_d    = work_q;
        case (state_q)
            IDLE: begin
                if (i_val && o_rdy_q) begin
                    work_d    = i_dat;
                    carry_d   = '0;
                    grp_d     = '0;
                    o_carry_d = '0;
                    state_d   = PROP;
`ifdef REDUN_CARRY_BYPASS_EN
                    if (in_canonical) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            PROP: begin
                work_d  = prop_work;
                carry_d = prop_carry;
                if (grp_q == LAST_GRP) begin
                    o_carry_d = prop_carry;
                    state_d   = DONE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                if (i_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the state being entered.
        o_rdy_d = (state_d == IDLE);
        o_val_d = (state_d == DONE);
    end

    // State register; reset aborts any operation and clears every output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grp_q     <= '0;
            carry_q   <= '0;
            o_carry_q <= '0;
            o_val_q   <= 1'b0;
            o_rdy_q   <= 1'b0;
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
                work_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grp_q     <= grp_d;
            carry_q   <= carry_d;
            o_carry_q <= o_carry_d;
            o_val_q   <= o_val_d;
            o_rdy_q   <= o_rdy_d;
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
                work_q[k] <= work_d[k];
            end
        end
    end

    // Output limbs are the low word of each working limb.
    generate
        for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_out
            assign o_dat[gi] = work_q[gi][WORD_LEN-1:0];
        end
    endgenerate

    assign o_rdy   = o_rdy_q;
    assign o_val   = o_val_q;
    assign o_carry = o_carry_q;

endmodule

// File: tb/tb_redun_carry_resolver.sv
// Testbench for redun_carry_resolver. The reference result is the plain integer
// sum of the input limbs weighted by 2^(16k); output limbs and carry are read
// straight out of that big number.
module tb_redun_carry_resolver;

    localparam int N   = 66;
    localparam int DW  = 17;
    localparam int WW  = 16;
    localparam int LPC = 4;
    localparam int NG  = (N + LPC - 1) / LPC;
    localparam int BW  = WW * N + 16;

    typedef logic [DW-1:0] vec_t [N];

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_val;
    logic          o_rdy;
    logic [DW-1:0] i_dat [N];
    logic          o_val;
    logic          i_rdy;
    logic [WW-1:0] o_dat [N];
    logic [1:0]    o_carry;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 i_clk = ~i_clk;

    redun_carry_resolver #(
        .NUM_ELEMENTS (N),
        .DSP_BIT_LEN  (DW),
        .WORD_LEN     (WW),
        .LIMBS_PER_CYC(LPC)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_val  (i_val),
        .o_rdy  (o_rdy),
        .i_dat  (i_dat),
        .o_val  (o_val),
        .i_rdy  (i_rdy),
        .o_dat  (o_dat),
        .o_carry(o_carry)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value of the redundant input as one big integer.
    function automatic logic [BW-1:0] model(input vec_t d);
        logic [BW-1:0] big;
        big = '0;
        for (int k = 0; k < N; k++) begin
            big = big + (BW'(d[k]) << (WW * k));
        end
        return big;
    endfunction

    function automatic int exp_latency(input vec_t d);
`ifdef REDUN_CARRY_BYPASS_EN
        bit canon;
        canon = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (d[k] > DW'(17'h0FFFF)) canon = 1'b0;
        end
        return canon ? 1 : NG + 1;
`else
        return NG + 1;
`endif
    endfunction

    task automatic check_result(input string tag, input logic [BW-1:0] ref_v);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s.limb%0d", tag, k), 64'(o_dat[k]), 64'(ref_v[WW*k +: WW]));
        end
        check($sformatf("%s.carry", tag), 64'(o_carry), 64'(ref_v[WW*N +: 16]));
    endtask

    // One full transaction: accept, wait for o_val, stall, hand off.
    task automatic run_op(input string tag, input vec_t d, input int stall, input bit hold);
        logic [BW-1:0] ref_v;
        int lat;
        ref_v = model(d);
        @(negedge i_clk);
        check({tag, ".rdy_idle"}, 64'(o_rdy), 64'(1));
        i_dat = d;
        i_val = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        lat = 1;
        while (!o_val && lat < 100) begin
            if (hold) begin
                check({tag, ".rdy_prop"}, 64'(o_rdy), 64'(0));
                for (int k = 0; k < N; k++) i_dat[k] = DW'($urandom);
            end else begin
                i_val = 1'b0;
            end
            @(posedge i_clk);
            @(negedge i_clk);
            lat++;
        end
        i_val = 1'b0;
        check({tag, ".lat"}, 64'(lat), 64'(exp_latency(d)));
        for (int s = 0; s < stall; s++) begin
            check_result({tag, ".stall"}, ref_v);
            @(posedge i_clk);
            @(negedge i_clk);
            check({tag, ".val_hold"}, 64'(o_val), 64'(1));
        end
        check_result(tag, ref_v);
        i_rdy = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rdy = 1'b0;
        check({tag, ".val_drop"}, 64'(o_val), 64'(0));
        $display("op %s: stall=%0d hold=%0d latency=%0d carry=%0d", tag, stall, hold, lat, o_carry);
    endtask

    initial begin
        vec_t d;
        int mode;
        i_rst = 1'b1;
        i_val = 1'b0;
        i_rdy = 1'b0;
        for (int k = 0; k < N; k++) i_dat[k] = '0;

        // Reset values while reset is held.
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst.rdy", 64'(o_rdy), 64'(0));
        check("rst.val", 64'(o_val), 64'(0));
        check_result("rst", '0);
        i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check("rel.rdy", 64'(o_rdy), 64'(1));

        // Carry ripples the full length.
        for (int k = 0; k < N; k++) d[k] = 17'h0FFFF;
        d[0] = 17'h10000;
        run_op("ripple", d, 0, 1'b0);

        // Maximum limbs: exercises the 2-bit carry.
        for (int k = 0; k < N; k++) d[k] = 17'h1FFFF;
        run_op("maxlimb", d, 3, 1'b0);

        // Already-canonical vector (bypass candidate).
        for (int k = 0; k < N; k++) d[k] = DW'($urandom_range(0, 16'hFFFF));
        run_op("canon", d, 1, 1'b0);

        // i_val held with changing data through PROP.
        for (int k = 0; k < N; k++) d[k] = DW'($urandom);
        run_op("hold", d, 2, 1'b1);

        // Reset while processing group 8.
        for (int k = 0; k < N; k++) d[k] = DW'($urandom);
        @(negedge i_clk);
        i_dat = d;
        i_val = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_val = 1'b0;
        repeat (8) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
        check("abort.val_pre", 64'(o_val), 64'(0));
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("abort.rdy", 64'(o_rdy), 64'(0));
        check("abort.val", 64'(o_val), 64'(0));
        check_result("abort", '0);
        i_rst = 1'b0;
        for (int c = 0; c < NG + 4; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("abort.no_val", 64'(o_val), 64'(0));
        end
        for (int k = 0; k < N; k++) d[k] = DW'($urandom);
        run_op("post_abort", d, 1, 1'b0);

        // Randomized operations with random downstream stalls.
        for (int t = 0; t < 1000 && err_cnt < 40; t++) begin
            mode = $urandom_range(0, 3);
            for (int k = 0; k < N; k++) begin
                case (mode)
                    0: d[k] = DW'($urandom);
                    1: d[k] = ($urandom_range(0, 7) == 0) ? 17'h10000 | DW'($urandom_range(0, 3)) : 17'h0FFFF;
                    2: d[k] = DW'($urandom_range(0, 16'hFFFF));
                    default: d[k] = 17'h1FF00 | DW'($urandom_range(0, 255));
                endcase
            end
            run_op($sformatf("rnd%0d", t), d, $urandom_range(0, 5), $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
